// File: rtl/fpu_pkg.sv
// Shared types and default widths for the FPU multiplier datapath.
package fpu_pkg;

    localparam int FPU_EXP_W = 8;
    localparam int FPU_MAN_W = 23;

    typedef enum logic [1:0] {
        RNE = 2'b00,
        RTZ = 2'b01,
        RUP = 2'b10,
        RDN = 2'b11
    } rmode_e;

    // Width-independent part of the stage-1 register bundle; the exponent and
    // fraction live beside it because their widths follow the module parameters.
    typedef struct packed {
        logic   sign;
        rmode_e rmode;
        logic   zero;
        logic   tiny;
        logic   guard;
        logic   round;
        logic   sticky;
    } norm_stage_t;

endpackage

// File: rtl/fpu_lzc.sv
// Parametrised leading-zero counter; count is W when the input is all zero.
module fpu_lzc #(
    parameter  int W  = 47,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_data,
    output logic [CW-1:0] o_count,
    output logic          o_all_zero
);

    // NOTE: the default before the loop keeps this block latch-free; the
    // highest set bit is the last match and therefore wins.
    always_comb begin
        o_count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (i_data[i]) o_count = CW'(W - 1 - i);
        end
    end

    assign o_all_zero = (i_data == '0);

endmodule

// File: rtl/mul_norm_round.sv
// Two-stage normalise/round/pack stage for the FPU multiplier: stage 1 normalises
// and denormalises, stage 2 rounds, packs and raises exception flags.
module mul_norm_round
    import fpu_pkg::*;
#(
    parameter int EXP_W  = FPU_EXP_W,
    parameter int MAN_W  = FPU_MAN_W,
    parameter int PROD_W = 2 * (MAN_W + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic                   sign_i,
    input  logic [EXP_W+1:0]       exponent_i,
    input  logic [PROD_W-1:0]      mantissa_i,
    input  logic [1:0]             rmode_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [EXP_W+MAN_W:0]   result_o,
    output logic                   overflow_o,
    output logic                   underflow_o,
    output logic                   inexact_o
);

    localparam int XW   = EXP_W + 3;
    localparam int LW   = $clog2(PROD_W);
    localparam int SHW  = $clog2(MAN_W + 3);
    localparam int TSAT = MAN_W + 2;
    localparam int EMAX = 2 ** (EXP_W + 1) - 1;
    localparam int EOVF = 2 ** EXP_W - 1;

    logic                    w_adv1, w_adv2;
    logic                    r_s1_valid;
    norm_stage_t             r_s1, w_s1_d;
    logic [EXP_W+1:0]        r_s1_exp, w_s1_exp;
    logic [MAN_W-1:0]        r_s1_frac, w_s1_frac;

    logic [LW-1:0]           w_lzc, w_shamt;
    logic                    w_all_zero, w_zero, w_tiny, w_lost;
    logic [PROD_W-1:0]       w_norm;
    logic [PROD_W-2:0]       w_den, w_fin;
    logic signed [XW-1:0]    w_exp_n;
    logic [XW-1:0]           w_neg;
    logic [SHW-1:0]          w_tsh;

    assign w_adv2  = !valid_o || ready_i;
    assign w_adv1  = !r_s1_valid || w_adv2;
    assign ready_o = w_adv1;

    fpu_lzc #(.W(PROD_W - 1)) u_lzc (
        .i_data     (mantissa_i[PROD_W-2:0]),
        .o_count    (w_lzc),
        .o_all_zero (w_all_zero)
    );

    // Move the leading one to the top bit; an overflowed product needs no shift.
    assign w_zero  = !mantissa_i[PROD_W-1] && w_all_zero;
    assign w_shamt = mantissa_i[PROD_W-1] ? '0 : w_lzc + LW'(1);
    assign w_norm  = mantissa_i << w_shamt;
    assign w_exp_n = $signed({exponent_i[EXP_W+1], exponent_i}) + XW'(1) - XW'(w_shamt);

    // Tiny results are denormalised by (1 - exp); every dropped bit feeds sticky.
    assign w_tiny = w_exp_n[XW-1] || (w_exp_n == '0);
    assign w_neg  = XW'(1) - w_exp_n;
    assign w_tsh  = (w_neg > XW'(TSAT)) ? SHW'(TSAT) : w_neg[SHW-1:0];
    assign w_den  = (PROD_W-1)'(w_norm >> w_tsh);
    assign w_lost = |(w_norm & ((PROD_W'(1) << w_tsh) - PROD_W'(1)));
    assign w_fin  = w_tiny ? w_den : w_norm[PROD_W-2:0];

    always_comb begin
        w_s1_d       = '0;
        w_s1_exp     = '0;
        w_s1_frac    = '0;
        w_s1_d.sign  = sign_i;
        w_s1_d.rmode = rmode_e'(rmode_i);
        if (w_zero) begin
            w_s1_d.zero = 1'b1;
        end else begin
            w_s1_d.tiny   = w_tiny;
            w_s1_frac     = w_fin[PROD_W-2 -: MAN_W];
            w_s1_d.guard  = w_fin[MAN_W];
            w_s1_d.round  = w_fin[MAN_W-1];
            w_s1_d.sticky = (|w_fin[MAN_W-2:0]) | (w_tiny & w_lost);
            if (w_tiny)                     w_s1_exp = '0;
            else if (w_exp_n > XW'(EMAX))   w_s1_exp = (EXP_W+2)'(EMAX);
            else                            w_s1_exp = w_exp_n[EXP_W+1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk_i) begin
        if (rst_i)       r_s1_valid <= 1'b0;
        else if (w_adv1) r_s1_valid <= valid_i;
    end

    // NOTE: the stage-1 datapath is deliberately left out of reset; r_s1_valid
    // qualifies it, so stale contents are never observed.
    always_ff @(posedge clk_i) begin
        if (valid_i && w_adv1) begin
            r_s1      <= w_s1_d;
            r_s1_exp  <= w_s1_exp;
            r_s1_frac <= w_s1_frac;
        end
    end

    logic                  w_inexact, w_inc, w_ovf, w_to_inf;
    logic [MAN_W:0]        w_frac_r;
    logic [EXP_W+2:0]      w_exp_r;
    logic [EXP_W+MAN_W:0]  w_result;

    assign w_inexact = r_s1.guard | r_s1.round | r_s1.sticky;

    always_comb begin
        w_inc = 1'b0;
        case (r_s1.rmode)
            RNE: w_inc = r_s1.guard & (r_s1.round | r_s1.sticky | r_s1_frac[0]);
            RTZ: w_inc = 1'b0;
            RUP: w_inc = !r_s1.sign & w_inexact;
            RDN: w_inc = r_s1.sign & w_inexact;
        endcase
    end

    // A fraction carry bumps the exponent, which also lifts a subnormal to exp 1.
    assign w_frac_r = {1'b0, r_s1_frac} + (MAN_W+1)'(w_inc);
    assign w_exp_r  = {1'b0, r_s1_exp} + (EXP_W+3)'(w_frac_r[MAN_W]);
    assign w_ovf    = w_exp_r >= (EXP_W+3)'(EOVF);
    assign w_to_inf = (r_s1.rmode == RNE) || (r_s1.rmode == RUP && !r_s1.sign) ||
                      (r_s1.rmode == RDN && r_s1.sign);

    always_comb begin
        w_result = {r_s1.sign, w_exp_r[EXP_W-1:0], w_frac_r[MAN_W-1:0]};
        if (r_s1.zero)
            w_result = {r_s1.sign, {(EXP_W+MAN_W){1'b0}}};
        else if (w_ovf && w_to_inf)
            w_result = {r_s1.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (w_ovf)
            w_result = {r_s1.sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o     <= 1'b0;
            result_o    <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            inexact_o   <= 1'b0;
        end else if (w_adv2) begin
            valid_o <= r_s1_valid;
            if (r_s1_valid) begin
                result_o    <= w_result;
                overflow_o  <= w_ovf && !r_s1.zero;
                underflow_o <= r_s1.tiny && w_inexact;
                inexact_o   <= (w_inexact || w_ovf) && !r_s1.zero;
            end
        end
    end

endmodule

// File: doc/mul_norm_round.md
Name: mul_norm_round

Overview:
- Parametrised normalise-and-round stage for the FPU multiplier datapath. Sits between the mantissa product array and result writeback.
- Takes the raw double-width significand product and the pre-biased exponent sum. Produces a packed IEEE-754 result with IEEE rounding, subnormal handling and exception flags.
- Two-stage pipeline with a valid/ready handshake. Replaces the fixed 5-position combinational normaliser.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width (hidden bit excluded).
- PROD_W, 2*(MAN_W+1), product width. Derived; do not override.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  input transaction valid
- ready_o  out  1  block can accept input this cycle
- sign_i  in  1  product sign
- exponent_i  in  EXP_W+2  signed biased exponent sum (ea+eb-bias), range -2^(EXP_W+1)..2^(EXP_W+1)-1
- mantissa_i  in  PROD_W  product; bit PROD_W-1 weight 2^1, bit PROD_W-2 weight 2^0
- rmode_i  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf)
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- result_o  out  1+EXP_W+MAN_W  packed {sign, exp, frac}
- overflow_o  out  1  overflow flag, qualified by valid_o
- underflow_o  out  1  underflow flag (tiny and inexact), qualified by valid_o
- inexact_o  out  1  inexact flag, qualified by valid_o

Behaviour:
- Handshake
  - Input is accepted when valid_i && ready_o. Output is consumed when valid_o && ready_i.
  - Stage advance: adv2 = !valid_o || ready_i; adv1 = !s1_valid || adv2; ready_o = adv1.
  - While valid_o && !ready_i, result_o and all flags hold stable.
  - Latency is 2 cycles from accept to valid_o with no backpressure. Throughput is 1 per cycle.
- Reset
  - Synchronous, active-high. Clears s1_valid and valid_o.
  - result_o and all flags reset to 0.
  - Reset mid-operation discards in-flight data. ready_o = 1 in the first cycle after reset deasserts.
- Stage 1 (normalise)
  - If mantissa_i == 0: zero path. Result is {sign_i, 0, 0}, no flags.
  - Else if bit PROD_W-1 is set: shift right by 1, exp+1. The shifted-out bit joins sticky.
  - Else: count leading zeros L over bits [PROD_W-2:0] via sub-module; shift left by L, exp-L. The full range 0..PROD_W-2 is supported.
  - Tiny case: if the normalised exp <= 0, right-shift by (1-exp), saturated at MAN_W+2. All shifted-out bits OR into sticky; the exp field becomes 0.
  - Registered outputs: sign, exp (EXP_W+2 signed), fraction, guard, round, sticky, rmode, zero, tiny.
- Stage 2 (round and pack)
  - Round-up condition by mode:
    - RNE: G && (R || S || lsb).
    - RTZ: never.
    - RUP: !sign && (G||R||S).
    - RDN: sign && (G||R||S).
  - inexact = G||R||S.
  - Fraction carry-out increments exp and zeroes the fraction. A subnormal rounding up into the minimum normal sets exp = 1.
  - Overflow when exp >= 2^EXP_W-1 after rounding. overflow_o = 1 and inexact_o = 1.
    - RNE, or the directed mode toward the result's sign: packed infinity.
    - Otherwise: max finite (exp all-ones minus 1, frac all-ones).
  - underflow_o = tiny && inexact (tininess detected before rounding).
- No NaN/inf input handling; special operands are resolved upstream.

Decomposition:
- Package fpu_pkg:
  - rmode_e enum (RNE, RTZ, RUP, RDN).
  - Default EXP_W/MAN_W constants.
  - Struct norm_stage_t for the stage-1 register bundle.
- Sub-module fpu_lzc: parametrised leading-zero counter.
  - Input width W; outputs count [$clog2(W+1)-1:0] and all_zero.
  - Purely combinational.

Test Plan:
- 1.5*1.5: exponent_i=127, mantissa_i=48'h9000_0000_0000, RNE -> after 2 cycles result_o=32'h4010_0000, all flags 0.
- Deep left shift: exponent_i=130, mantissa_i=48'h0200_0000_0000 (bit 41), RNE -> 32'h3E80_0000, flags 0.
- Tie rounding: exponent_i=127, mantissa_i=48'h4000_0040_0000, sign 0.
  - RNE -> 32'h3F80_0000.
  - RUP -> 32'h3F80_0001.
  - inexact_o=1 in both modes.
- Overflow: exponent_i=255, mantissa_i=48'h4000_0000_0000.
  - RNE -> 32'h7F80_0000.
  - RTZ -> 32'h7F7F_FFFF.
  - overflow_o=1 in both.
- Subnormal: exponent_i=0, mantissa_i=48'h4000_0000_0000 -> 32'h0040_0000, underflow_o=0.
  - With bit 0 also set: inexact_o=1 and underflow_o=1.
- Backpressure/reset:
  - 4 back-to-back inputs with ready_i held low 3 cycles -> ready_o drops once both stages are full; all 4 results emerge in order with no loss or duplication.
  - rst_i pulsed mid-stream -> valid_o=0 next cycle.
